// File: rtl/hack_run_ctrl.sv
// Load/run/halt harness for the HACK CPU: streamed program loader, zero-latency
// instruction/data memories, halt-loop and cycle-budget detection.
module hack_run_ctrl #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned IADDR_W    = 10,
    parameter int unsigned DADDR_W    = 10,
    parameter int unsigned MAX_CYCLES = 65535
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [WIDTH-1:0]   ld_data,
    input  logic               ld_last,
    output logic               ld_err,
    input  logic               start,
    output logic [WIDTH-1:0]   cpu_inst,
    output logic [WIDTH-1:0]   cpu_inM,
    output logic               cpu_reset,
    input  logic [WIDTH-1:0]   cpu_outM,
    input  logic [WIDTH-1:0]   cpu_addressM,
    input  logic [WIDTH-1:0]   cpu_pc,
    input  logic               cpu_wen,
    output logic               busy,
    output logic               halted,
    output logic               timeout,
    output logic [31:0]        cycle_count,
    input  logic [DADDR_W-1:0] dbg_addr,
    output logic [WIDTH-1:0]   dbg_data
);
    localparam int unsigned IDEPTH = 1 << IADDR_W;
    localparam int unsigned DDEPTH = 1 << DADDR_W;
    localparam int unsigned CMP_W  = (WIDTH > IADDR_W + 1) ? WIDTH : IADDR_W + 1;
    localparam logic [IADDR_W:0] PTR_ONE = 1;

    typedef enum logic [2:0] {IDLE, LOAD, READY, RUN, HALT} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0] imem [IDEPTH];
    logic [WIDTH-1:0] dmem [DDEPTH];

    // One extra bit so the pointer can hold the full-memory value 2^IADDR_W.
    logic [IADDR_W:0] ld_ptr, prog_len;
    logic [WIDTH-1:0] h1, h2, h3, p_inc;
    logic [1:0]       hist_vld;
    logic [31:0]      cycle_nxt;
    logic             ld_fire, ld_full, halt_hit, budget_hit, pc_ok, addr_ok, run_start;

    assign ld_fire    = ld_valid && ld_ready;
    assign ld_full    = ld_ptr[IADDR_W];
    assign p_inc      = h3 + WIDTH'(1);
    assign halt_hit   = (hist_vld == 2'd3) && (h2 == p_inc) && (h1 == h3) && (cpu_pc == p_inc);
    assign cycle_nxt  = cycle_count + 32'd1;
    assign budget_hit = (cycle_nxt == MAX_CYCLES);
    assign run_start  = start && ((state == READY) || (state == HALT));

    assign pc_ok    = CMP_W'(cpu_pc) < CMP_W'(prog_len);
    assign addr_ok  = (cpu_addressM >> DADDR_W) == '0;
    assign cpu_inst = pc_ok ? imem[cpu_pc[IADDR_W-1:0]] : '0;
    assign cpu_inM  = addr_ok ? dmem[cpu_addressM[DADDR_W-1:0]] : '0;
    assign dbg_data = dmem[dbg_addr];

    always_comb begin
        state_nxt = state;
        ld_ready  = 1'b0;
        busy      = 1'b0;
        halted    = 1'b0;
        cpu_reset = 1'b1;
        unique case (state)
            IDLE: begin
                ld_ready = 1'b1;
                if (ld_valid) state_nxt = ld_last ? READY : LOAD;
            end
            LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid && ld_last) state_nxt = READY;
            end
            READY: if (start) state_nxt = RUN;
            RUN: begin
                busy      = 1'b1;
                cpu_reset = 1'b0;
                if (halt_hit || budget_hit) state_nxt = HALT;
            end
            HALT: begin
                halted = 1'b1;
                if (start) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ld_ptr      <= '0;
            prog_len    <= '0;
            ld_err      <= 1'b0;
            cycle_count <= '0;
            timeout     <= 1'b0;
            hist_vld    <= '0;
            h1          <= '0;
            h2          <= '0;
            h3          <= '0;
        end else begin
            state <= state_nxt;
            if (ld_fire) begin
                if (ld_full) begin
                    ld_err <= 1'b1;
                end else begin
                    ld_ptr   <= ld_ptr + PTR_ONE;
                    prog_len <= ld_ptr + PTR_ONE;
                end
            end
            if (run_start) begin
                cycle_count <= '0;
                timeout     <= 1'b0;
                hist_vld    <= '0;
            end
            if (state == RUN) begin
                cycle_count <= cycle_nxt;
                h3          <= h2;
                h2          <= h1;
                h1          <= cpu_pc;
                if (hist_vld != 2'd3) hist_vld <= hist_vld + 2'd1;
                if (budget_hit && !halt_hit) timeout <= 1'b1;
            end
        end
    end

    // Memories are deliberately left out of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (!reset && ld_fire && !ld_full)
            imem[ld_ptr[IADDR_W-1:0]] <= ld_data;
        if (!reset && (state == RUN) && cpu_wen && addr_ok)
            dmem[cpu_addressM[DADDR_W-1:0]] <= cpu_outM;
    end

endmodule

// File: tb/tb_hack_run_ctrl.sv
// Directed bench for hack_run_ctrl: the bench plays the CPU by driving pc,
// address and write pins directly, cycle by cycle.
module tb_hack_run_ctrl;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, ld_valid, ld_last, start, cpu_wen;
    logic [15:0] ld_data, cpu_outM, cpu_addressM, cpu_pc;
    logic [9:0]  dbg_addr;
    logic        ld_ready, ld_err, cpu_reset, busy, halted, timeout;
    logic [15:0] cpu_inst, cpu_inM, dbg_data;
    logic [31:0] cycle_count;

    logic        ld_valid_b, ld_last_b, start_b;
    logic [15:0] ld_data_b;
    logic        ld_ready_b, ld_err_b, cpu_reset_b, busy_b, halted_b, timeout_b;
    logic [15:0] cpu_inst_b, cpu_inM_b, dbg_data_b;
    logic [31:0] cycle_count_b;

    int vectors = 0;
    int miscompares = 0;

    hack_run_ctrl #(.WIDTH(16), .IADDR_W(3), .DADDR_W(10), .MAX_CYCLES(20)) dut (
        .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_data(ld_data), .ld_last(ld_last), .ld_err(ld_err), .start(start),
        .cpu_inst(cpu_inst), .cpu_inM(cpu_inM), .cpu_reset(cpu_reset),
        .cpu_outM(cpu_outM), .cpu_addressM(cpu_addressM), .cpu_pc(cpu_pc),
        .cpu_wen(cpu_wen), .busy(busy), .halted(halted), .timeout(timeout),
        .cycle_count(cycle_count), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    hack_run_ctrl #(.WIDTH(16), .IADDR_W(2), .DADDR_W(10), .MAX_CYCLES(65535)) dut_b (
        .clk(clk), .reset(reset), .ld_valid(ld_valid_b), .ld_ready(ld_ready_b),
        .ld_data(ld_data_b), .ld_last(ld_last_b), .ld_err(ld_err_b), .start(start_b),
        .cpu_inst(cpu_inst_b), .cpu_inM(cpu_inM_b), .cpu_reset(cpu_reset_b),
        .cpu_outM(cpu_outM), .cpu_addressM(cpu_addressM), .cpu_pc(cpu_pc),
        .cpu_wen(1'b0), .busy(busy_b), .halted(halted_b), .timeout(timeout_b),
        .cycle_count(cycle_count_b), .dbg_addr(dbg_addr), .dbg_data(dbg_data_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; ld_valid = 1'b0; ld_last = 1'b0; start = 1'b0; cpu_wen = 1'b0;
        ld_data = '0; cpu_outM = '0; cpu_addressM = '0; cpu_pc = '0; dbg_addr = '0;
        ld_valid_b = 1'b0; ld_last_b = 1'b0; start_b = 1'b0; ld_data_b = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        vectors++; if (ld_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ld_ready: got %b want 1", ld_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL rst_halted: got %b want 0", halted); end
        vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL rst_timeout: got %b want 0", timeout); end
        vectors++; if (cycle_count !== 32'd0) begin miscompares++; $display("FAIL rst_cycle_count: got %0d want 0", cycle_count); end
        vectors++; if (cpu_reset !== 1'b1) begin miscompares++; $display("FAIL rst_cpu_reset: got %b want 1", cpu_reset); end
        vectors++; if (ld_err !== 1'b0) begin miscompares++; $display("FAIL rst_ld_err: got %b want 0", ld_err); end
        vectors++; if (cpu_inst !== 16'h0000) begin miscompares++; $display("FAIL rst_cpu_inst: got %h want 0000", cpu_inst); end
        vectors++; if (ld_err_b !== 1'b0) begin miscompares++; $display("FAIL rst_ld_err_b: got %b want 0", ld_err_b); end
    endtask

    task automatic test_overflow();
        logic [15:0] w [6];
        logic [15:0] exp;
        w = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
        for (int i = 0; i < 6; i++) begin
            ld_valid_b = 1'b1; ld_data_b = w[i]; ld_last_b = (i == 5);
            tick();
            if (i == 3) begin
                vectors++; if (ld_err_b !== 1'b0) begin miscompares++; $display("FAIL ovf_err_at_full: got %b want 0", ld_err_b); end
            end
            if (i == 4) begin
                vectors++; if (ld_err_b !== 1'b1) begin miscompares++; $display("FAIL ovf_err_set: got %b want 1", ld_err_b); end
                vectors++; if (ld_ready_b !== 1'b1) begin miscompares++; $display("FAIL ovf_ready_in_load: got %b want 1", ld_ready_b); end
            end
        end
        ld_valid_b = 1'b0; ld_last_b = 1'b0;
        #1;
        vectors++; if (ld_ready_b !== 1'b0) begin miscompares++; $display("FAIL ovf_ready_after_last: got %b want 0", ld_ready_b); end
        vectors++; if (ld_err_b !== 1'b1) begin miscompares++; $display("FAIL ovf_err_sticky: got %b want 1", ld_err_b); end
        for (int pc = 0; pc < 5; pc++) begin
            cpu_pc = 16'(pc);
            exp = (pc < 4) ? w[pc] : 16'h0000;
            #1;
            vectors++; if (cpu_inst_b !== exp) begin miscompares++; $display("FAIL ovf_imem pc=%0d: got %h want %h", pc, cpu_inst_b, exp); end
        end
        cpu_pc = '0;
    endtask

    task automatic test_store_halt();
        logic [15:0] prog [6];
        int pcs [8];
        prog = '{16'h000b, 16'hec10, 16'h0010, 16'he308, 16'h0004, 16'hea87};
        pcs = '{0, 1, 2, 3, 4, 5, 4, 5};
        #1;
        vectors++; if (ld_ready !== 1'b1) begin miscompares++; $display("FAIL sh_ready_idle: got %b want 1", ld_ready); end
        for (int i = 0; i < 6; i++) begin
            ld_valid = 1'b1; ld_data = prog[i]; ld_last = (i == 5);
            tick();
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        vectors++; if (ld_ready !== 1'b0) begin miscompares++; $display("FAIL sh_ready_drop: got %b want 0", ld_ready); end
        vectors++; if (cpu_reset !== 1'b1) begin miscompares++; $display("FAIL sh_cpu_reset_ready: got %b want 1", cpu_reset); end
        start = 1'b1; tick(); start = 1'b0;
        cpu_addressM = 16'd16; cpu_outM = 16'h000b; dbg_addr = 10'd16;
        for (int k = 0; k < 8; k++) begin
            cpu_pc = 16'(pcs[k]);
            cpu_wen = (k == 3);
            #1;
            vectors++; if (cpu_inst !== prog[pcs[k]]) begin miscompares++; $display("FAIL sh_inst k=%0d: got %h want %h", k, cpu_inst, prog[pcs[k]]); end
            vectors++; if (cycle_count !== 32'(k)) begin miscompares++; $display("FAIL sh_count k=%0d: got %0d want %0d", k, cycle_count, k); end
            vectors++; if (busy !== 1'b1 || cpu_reset !== 1'b0) begin miscompares++; $display("FAIL sh_run k=%0d: busy=%b cpu_reset=%b want 1/0", k, busy, cpu_reset); end
            if (k == 4) begin
                vectors++; if (cpu_inM !== 16'h000b) begin miscompares++; $display("FAIL sh_inM_after_write: got %h want 000b", cpu_inM); end
            end
            tick();
        end
        cpu_wen = 1'b0;
        vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL sh_halted: got %b want 1", halted); end
        vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL sh_timeout: got %b want 0", timeout); end
        vectors++; if (cycle_count !== 32'd8) begin miscompares++; $display("FAIL sh_final_count: got %0d want 8", cycle_count); end
        vectors++; if (cpu_reset !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL sh_halt_pins: cpu_reset=%b busy=%b want 1/0", cpu_reset, busy); end
        vectors++; if (dbg_data !== 16'h000b) begin miscompares++; $display("FAIL sh_dmem16: got %h want 000b", dbg_data); end
        tick(); tick();
        vectors++; if (cycle_count !== 32'd8 || halted !== 1'b1) begin miscompares++; $display("FAIL sh_hold: count=%0d halted=%b want 8/1", cycle_count, halted); end
    endtask

    task automatic test_rerun();
        int pcs [8];
        pcs = '{0, 1, 2, 3, 4, 5, 4, 5};
        dbg_addr = 10'd16; cpu_wen = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        vectors++; if (halted !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL rr_enter: halted=%b busy=%b want 0/1", halted, busy); end
        vectors++; if (dbg_data !== 16'h000b) begin miscompares++; $display("FAIL rr_dmem_kept: got %h want 000b", dbg_data); end
        for (int k = 0; k < 8; k++) begin
            cpu_pc = 16'(pcs[k]);
            #1;
            vectors++; if (cycle_count !== 32'(k)) begin miscompares++; $display("FAIL rr_count k=%0d: got %0d want %0d", k, cycle_count, k); end
            tick();
        end
        vectors++; if (halted !== 1'b1 || cycle_count !== 32'd8) begin miscompares++; $display("FAIL rr_halt: halted=%b count=%0d want 1/8", halted, cycle_count); end
        vectors++; if (dbg_data !== 16'h000b) begin miscompares++; $display("FAIL rr_dmem_end: got %h want 000b", dbg_data); end
    endtask

    task automatic test_out_of_range();
        start = 1'b1; tick(); start = 1'b0;
        cpu_pc = 16'd0; cpu_wen = 1'b1; cpu_addressM = 16'd0; cpu_outM = 16'h1234; dbg_addr = 10'd0;
        tick();
        cpu_pc = 16'd8; cpu_wen = 1'b1; cpu_addressM = 16'd1024; cpu_outM = 16'hffff;
        #1;
        vectors++; if (cpu_inst !== 16'h0000) begin miscompares++; $display("FAIL oor_inst_pc8: got %h want 0000", cpu_inst); end
        vectors++; if (cpu_inM !== 16'h0000) begin miscompares++; $display("FAIL oor_inM_1024: got %h want 0000", cpu_inM); end
        vectors++; if (dbg_data !== 16'h1234) begin miscompares++; $display("FAIL oor_dmem0_written: got %h want 1234", dbg_data); end
        tick();
        cpu_wen = 1'b0; cpu_pc = 16'd6;
        #1;
        vectors++; if (cpu_inst !== 16'h0000) begin miscompares++; $display("FAIL oor_inst_pc6: got %h want 0000", cpu_inst); end
        vectors++; if (dbg_data !== 16'h1234) begin miscompares++; $display("FAIL oor_dmem0_kept: got %h want 1234", dbg_data); end
        vectors++; if (cycle_count !== 32'd2) begin miscompares++; $display("FAIL oor_count: got %0d want 2", cycle_count); end
    endtask

    task automatic test_reset_mid_run();
        reset = 1'b1; tick(); reset = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0 || cpu_reset !== 1'b1) begin miscompares++; $display("FAIL mr_pins: busy=%b cpu_reset=%b want 0/1", busy, cpu_reset); end
        vectors++; if (cycle_count !== 32'd0) begin miscompares++; $display("FAIL mr_count: got %0d want 0", cycle_count); end
        vectors++; if (ld_ready !== 1'b1) begin miscompares++; $display("FAIL mr_ld_ready: got %b want 1", ld_ready); end
        start = 1'b1; tick(); start = 1'b0;
        vectors++; if (busy !== 1'b0 || cpu_reset !== 1'b1 || ld_ready !== 1'b1) begin miscompares++; $display("FAIL mr_start_ignored: busy=%b cpu_reset=%b ld_ready=%b want 0/1/1", busy, cpu_reset, ld_ready); end
        vectors++; if (dbg_data !== 16'h1234) begin miscompares++; $display("FAIL mr_dmem_kept: got %h want 1234", dbg_data); end
    endtask

    task automatic test_timeout();
        logic [15:0] prog [3];
        logic [15:0] exp;
        prog = '{16'h0000, 16'hec10, 16'hea87};
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_data = prog[i]; ld_last = (i == 2);
            tick();
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        for (int pc = 0; pc < 4; pc++) begin
            cpu_pc = 16'(pc);
            exp = (pc < 3) ? prog[pc] : 16'h0000;
            #1;
            vectors++; if (cpu_inst !== exp) begin miscompares++; $display("FAIL to_reload pc=%0d: got %h want %h", pc, cpu_inst, exp); end
        end
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cpu_pc = 16'(k % 3);
            #1;
            if (k == 19) begin
                vectors++; if (busy !== 1'b1 || cycle_count !== 32'd19) begin miscompares++; $display("FAIL to_cycle20: busy=%b count=%0d want 1/19", busy, cycle_count); end
            end
            tick();
        end
        vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL to_halted: got %b want 1", halted); end
        vectors++; if (timeout !== 1'b1) begin miscompares++; $display("FAIL to_timeout: got %b want 1", timeout); end
        vectors++; if (cycle_count !== 32'd20) begin miscompares++; $display("FAIL to_count: got %0d want 20", cycle_count); end
    endtask

    task automatic test_halt_beats_timeout();
        start = 1'b1; tick(); start = 1'b0;
        vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL hb_timeout_cleared: got %b want 0", timeout); end
        for (int k = 0; k < 20; k++) begin
            cpu_pc = (k < 16) ? 16'(k % 3) : ((k % 2 == 0) ? 16'd4 : 16'd5);
            tick();
        end
        vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL hb_halted: got %b want 1", halted); end
        vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL hb_timeout: got %b want 0", timeout); end
        vectors++; if (cycle_count !== 32'd20) begin miscompares++; $display("FAIL hb_count: got %0d want 20", cycle_count); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_overflow();
        test_store_halt();
        test_rerun();
        test_out_of_range();
        test_reset_mid_run();
        test_timeout();
        test_halt_beats_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
